// File: rtl/ccu_resp_pkg.sv
// ---------------------------------------------------------------------------
// Module : ccu_resp_pkg
// Brief  : Shared types, default widths and delay helper for the CCU responder.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ccu_resp_pkg;

  localparam int unsigned CCU_DLY_W_DEF   = 8;
  localparam int unsigned CCU_USYNC_W_DEF = 10;

  typedef enum logic [2:0] {
    GATED       = 3'd0,
    UNGATE_WAIT = 3'd1,
    ACK_WAIT    = 3'd2,
    ON          = 3'd3,
    DEACK_WAIT  = 3'd4,
    GATE_WAIT   = 3'd5
  } ccu_resp_state_e;

  // A programmed delay of zero still costs one cycle.
  function automatic logic [31:0] dly_sat1(input logic [31:0] dly);
    return (dly == 32'd0) ? 32'd1 : dly;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccu_resp_slice_fsm.sv
// ---------------------------------------------------------------------------
// Module : ccu_resp_slice_fsm
// Brief  : One slice's 4-phase clkreq/clk_en/clkack handshake with delay counter.
//          Optional sticky protocol check under CCU_RESP_PROTO_CHECK_EN.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccu_resp_slice_fsm
  import ccu_resp_pkg::*;
#(
  parameter int unsigned DLY_W = CCU_DLY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [DLY_W-1:0] cfg_req1_clk1,
  input  logic [DLY_W-1:0] cfg_clk1_ack1,
  input  logic [DLY_W-1:0] cfg_req0_ack0,
  input  logic [DLY_W-1:0] cfg_ack0_clk0,
  output logic             clk_en,
  output logic             clkack,
  output logic             clkack_nxt,
  output logic             proto_err
);

  ccu_resp_state_e  state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             clkack_q, clkack_d;
  logic             cnt_done;

  function automatic logic [DLY_W-1:0] load_dly(input logic [DLY_W-1:0] v);
    return DLY_W'(dly_sat1(32'(v)));
  endfunction

  assign cnt_done = (cnt_q == DLY_W'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    clkack_d = clkack_q;
    case (state_q)
      GATED: begin
        if (req) begin
          state_d = UNGATE_WAIT;
          cnt_d   = load_dly(cfg_req1_clk1);
        end
      end
      UNGATE_WAIT: begin
        if (cnt_done) begin
          clk_en_d = 1'b1;
          state_d  = ACK_WAIT;
          cnt_d    = load_dly(cfg_clk1_ack1);
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ACK_WAIT: begin
        if (cnt_done) begin
          clkack_d = 1'b1;
          state_d  = ON;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ON: begin
        if (!req) begin
          state_d = DEACK_WAIT;
          cnt_d   = load_dly(cfg_req0_ack0);
        end
      end
      DEACK_WAIT: begin
        if (cnt_done) begin
          clkack_d = 1'b0;
          state_d  = GATE_WAIT;
          cnt_d    = load_dly(cfg_ack0_clk0);
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      GATE_WAIT: begin
        if (cnt_done) begin
          clk_en_d = 1'b0;
          state_d  = GATED;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      default: state_d = GATED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= GATED;
      cnt_q    <= '0;
      clk_en_q <= 1'b0;
      clkack_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      clkack_q <= clkack_d;
    end
  end

  assign clk_en     = clk_en_q;
  assign clkack     = clkack_q;
  assign clkack_nxt = clkack_d;

`ifdef CCU_RESP_PROTO_CHECK_EN
  logic err_q, err_d;

  // Req dropping before the ack phase completes, or rising before the gate closes.
  always_comb begin
    err_d = err_q;
    if (((state_q == UNGATE_WAIT) || (state_q == ACK_WAIT)) && !req) err_d = 1'b1;
    if (((state_q == DEACK_WAIT) || (state_q == GATE_WAIT)) && req)  err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/ccu_clkreq_responder.sv
// ---------------------------------------------------------------------------
// Module : ccu_clkreq_responder
// Brief  : Multi-slice CCU clkreq responder with globalusync/usync generation.
//          Define CCU_RESP_PROTO_CHECK_EN to enable sticky proto_err reporting.
// Rev    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccu_clkreq_responder
  import ccu_resp_pkg::*;
#(
  parameter int unsigned NUM_SLICES = 1,
  parameter int unsigned DLY_W      = CCU_DLY_W_DEF,
  parameter int unsigned USYNC_W    = CCU_USYNC_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SLICES-1:0]       clkreq,
  input  logic [NUM_SLICES*DLY_W-1:0] cfg_req1_clk1,
  input  logic [NUM_SLICES*DLY_W-1:0] cfg_clk1_ack1,
  input  logic [NUM_SLICES*DLY_W-1:0] cfg_req0_ack0,
  input  logic [NUM_SLICES*DLY_W-1:0] cfg_ack0_clk0,
  input  logic [USYNC_W-1:0]          usync_period,
  output logic [NUM_SLICES-1:0]       clk_en,
  output logic [NUM_SLICES-1:0]       clkack,
  output logic [NUM_SLICES-1:0]       usync,
  output logic                        globalusync,
  output logic [NUM_SLICES-1:0]       proto_err
);

  logic [NUM_SLICES-1:0] clkreq_q, clkreq_d;
  logic [NUM_SLICES-1:0] clkack_nxt;
  logic [USYNC_W-1:0]    ucnt_q, ucnt_d;
  logic [USYNC_W-1:0]    uper_q, uper_d;
  logic                  gsync_q, gsync_d;
  logic [NUM_SLICES-1:0] usync_q, usync_d;
  logic                  usync_wrap;

  assign clkreq_d = clkreq;

  // uper_q holds the period in force; a new period is only picked up at a wrap
  // or while the generator is idle (uper_q == 0).
  always_comb begin
    usync_wrap = (uper_q != '0) && (ucnt_q == (uper_q - USYNC_W'(1)));
    ucnt_d     = ucnt_q + USYNC_W'(1);
    uper_d     = uper_q;
    if ((uper_q == '0) || usync_wrap) begin
      ucnt_d = '0;
      uper_d = usync_period;
    end
    gsync_d = usync_wrap;
    usync_d = {NUM_SLICES{usync_wrap}} & clkack_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clkreq_q <= '0;
      ucnt_q   <= '0;
      uper_q   <= '0;
      gsync_q  <= 1'b0;
      usync_q  <= '0;
    end else begin
      clkreq_q <= clkreq_d;
      ucnt_q   <= ucnt_d;
      uper_q   <= uper_d;
      gsync_q  <= gsync_d;
      usync_q  <= usync_d;
    end
  end

  generate
    for (genvar i = 0; i < NUM_SLICES; i++) begin : g_slice
      ccu_resp_slice_fsm #(
        .DLY_W (DLY_W)
      ) u_slice (
        .clk           (clk),
        .reset         (reset),
        .req           (clkreq_q[i]),
        .cfg_req1_clk1 (cfg_req1_clk1[i*DLY_W +: DLY_W]),
        .cfg_clk1_ack1 (cfg_clk1_ack1[i*DLY_W +: DLY_W]),
        .cfg_req0_ack0 (cfg_req0_ack0[i*DLY_W +: DLY_W]),
        .cfg_ack0_clk0 (cfg_ack0_clk0[i*DLY_W +: DLY_W]),
        .clk_en        (clk_en[i]),
        .clkack        (clkack[i]),
        .clkack_nxt    (clkack_nxt[i]),
        .proto_err     (proto_err[i])
      );
    end
  endgenerate

  assign globalusync = gsync_q;
  assign usync       = usync_q;

endmodule

`default_nettype wire
